pipelined_logic_unit: RTL and testbench
=======================================

Name: pipelined_logic_unit

Overview:
- Parametrised, pipelined successor to the team's 4-bit, 4-op combinational logic unit.
- Operand width is configurable and the op set is extended to 8 bitwise operations.
- Adds a 2-stage registered datapath with valid/ready handshakes, zero/parity flags, and an accumulate mode (operand a replaced by the previous result).
- Sits between an operand-issuing controller and a result consumer that may apply backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- OP_W, 3, opcode width; fixed at 3, exposed for the package only.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b.
- op  input  3  opcode.
- use_acc  input  1  1 = replace a with the accumulator.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- parity  output  1  XOR-reduce of result.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the clk rising edge.
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 NOT a (b ignored).
  - 100 NAND, 101 NOR, 110 XNOR, 111 PASS b.
  - Codes 000-011 match the legacy 2-bit encoding.
- Stage 1 (S1): registers a, b, op, use_acc and s1_valid.
- Stage 2 (S2): computes the op and registers result, zero, parity, out_valid.
- Accumulator (acc, internal, WIDTH bits): loads the computed result every cycle S2 loads a valid beat.
- use_acc=1: the S2 computation uses acc in place of S1's a.
  - Because beats reach S2 strictly in order, acc always equals the previous beat's result. No hazard, no forwarding.
- Handshake and stall:
  - s2_free = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_free (combinational, no dependence on in_valid).
  - Beat accepted iff in_valid && in_ready.
  - S2 loads when s1_valid && s2_free.
  - If s2_free && !s1_valid, out_valid clears.
  - When stalled (!s2_free), result, zero, parity, out_valid and all S1 registers hold.
  - When S1 moves to S2 and no new beat is accepted, s1_valid clears.
  - Bubbles collapse: a beat accepted into an empty pipe may pass S1 while S2 holds.
- Latency: 2 cycles from acceptance to out_valid with no backpressure. Throughput 1 beat/cycle.
- Output register semantics:
  - result, zero and parity are registered with out_valid and stable while out_valid && !out_ready.
  - zero and parity always reflect the registered result.
- Reset:
  - s1_valid=0, out_valid=0, result=0, acc=0, zero=1, parity=0.
  - in_ready=1 after reset.
  - Reset mid-operation discards in-flight beats and clears acc.
- Boundary cases:
  - Simultaneous out_ready, S1 advance and new accept in one cycle is legal: all three transfers happen.
  - Inputs are ignored when in_valid=0 or in_ready=0.
  - Opcode is fully decoded (all 8 codes defined). No X on result for any op.
  - WIDTH=1 is legal: parity == result.

Decomposition:
- Package pipelined_logic_unit_pkg:
  - typedef enum logic [2:0] op_e {OP_AND, OP_OR, OP_XOR, OP_NOT_A, OP_NAND, OP_NOR, OP_XNOR, OP_PASS_B}.
  - localparam OP_W=3.
- Sub-module logic_op_core: purely combinational, parametrised WIDTH; inputs a, b, op_e; output result.
- Top module holds both pipeline registers, acc, handshake logic and flag generation.

Test Plan (WIDTH=4):
- After reset, out_ready=1: issue a=1100, b=1010 with ops 000, 001, 010, 011 on back-to-back cycles -> results 1000, 1110, 0110, 0011 on consecutive cycles. First result appears 2 cycles after acceptance; out_valid stays high across the 4 beats.
- Flags: XNOR a=0101, b=1010 -> result 0000, zero=1, parity=0. NAND a=0001, b=0011 -> 1110, zero=0, parity=1.
- Accumulate: PASS b=0110, then XOR use_acc=1 b=0011, then NOT use_acc=1 -> 0110, 0101, 1010.
  - Repeat with the beats issued back-to-back; results must be identical.
- Backpressure: hold out_ready=0 with 3 beats offered.
  - Result stays frozen at the first beat; in_ready drops after the 2nd beat is in S1.
  - Release out_ready -> the remaining beats emerge in order, none lost or duplicated.
- Reset mid-stream: assert reset with S1 and S2 both valid -> next cycle out_valid=0, result=0000, zero=1, in_ready=1. A subsequent XOR use_acc=1, b=1001 returns 1001 (acc cleared).
- Random beats with random out_ready, checked against a scoreboard reference model: zero loss, in-order delivery, throughput 1/cycle when out_ready=1.

Source files
------------

// File: rtl/pipelined_logic_unit_pkg.sv
// Shared opcode encoding and widths for the pipelined logic unit.
// Codes 000-011 keep the legacy 2-bit logic-unit meaning.
package pipelined_logic_unit_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_XOR    = 3'b010,
        OP_NOT_A  = 3'b011,
        OP_NAND   = 3'b100,
        OP_NOR    = 3'b101,
        OP_XNOR   = 3'b110,
        OP_PASS_B = 3'b111
    } op_e;

endpackage

// File: rtl/pipelined_logic_unit_logic_op_core.sv
// Purely combinational bitwise operation core; every opcode is decoded.
module logic_op_core
    import pipelined_logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_NOT_A:  result = ~a;
            OP_NAND:   result = ~(a & b);
            OP_NOR:    result = ~(a | b);
            OP_XNOR:   result = ~(a ^ b);
            OP_PASS_B: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/pipelined_logic_unit.sv
// Two-stage valid/ready logic unit with zero/parity flags and an accumulate mode
// in which operand a is replaced by the previously delivered result.
module pipelined_logic_unit
    import pipelined_logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic             s1_use_acc;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_res;
    logic             s2_free;
    logic             accept;

    // Output register can take a new value when empty or being drained.
    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;
    // Beats reach S2 in order, so acc is always the previous beat's result.
    assign core_a   = s1_use_acc ? acc : s1_a;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .a      (core_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (core_res)
    );

    // Stage 1: operand capture; an empty S1 accepts even while S2 is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= OP_AND;
            s1_use_acc <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_a       <= a;
            s1_b       <= b;
            s1_op      <= op_e'(op);
            s1_use_acc <= use_acc;
        end else if (s2_free) begin
            s1_valid   <= 1'b0;
        end
    end

    // Stage 2: result, flags and accumulator; everything holds while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
            acc       <= '0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= core_res;
                zero   <= ~|core_res;
                parity <= ^core_res;
                acc    <= core_res;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Self-checking bench for pipelined_logic_unit at WIDTH=4: directed vector table,
// backpressure and reset corner sequences, then random beats against a reference.
module tb_pipelined_logic_unit;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic         ua;
        logic [W-1:0] res;
        logic         z;
        logic         p;
        int           gap;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         p;
        bit           lat;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         use_acc = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         parity;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    exp_t         exp_q[$];
    exp_t         e;
    logic [W-1:0] model_acc = '0;
    bit           rand_done = 1'b0;
    vec_t         vecs[15];

    pipelined_logic_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .use_acc   (use_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .parity    (parity)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [2:0] o);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~x;
            3'd4:    return ~(x & y);
            3'd5:    return ~(x | y);
            3'd6:    return ~(x ^ y);
            default: return y;
        endcase
    endfunction

    // Present one beat, wait (bounded) for in_ready, queue the expected result.
    task automatic send(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic [2:0] op_i,
                        input logic ua_i, input logic [W-1:0] er, input logic ez, input logic ep,
                        input bit lat);
        int n;
        exp_t x;
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        a = a_i;
        b = b_i;
        op = op_i;
        use_acc = ua_i;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready got 0 expected 1");
        end else begin
            x.res = er;
            x.z = ez;
            x.p = ep;
            x.lat = lat;
            x.acc_cyc = cyc + 1;
            exp_q.push_back(x);
            model_acc = er;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    // Output monitor: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got %h expected none", result);
            end else begin
                e = exp_q.pop_front();
                chk("result_zero_parity", 32'({result, zero, parity}), 32'({e.res, e.z, e.p}));
                if (e.lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd1);
            end
        end
    end

    initial begin
        vecs[0]  = '{4'b1100, 4'b1010, 3'b000, 1'b0, 4'b1000, 1'b0, 1'b1, 0};
        vecs[1]  = '{4'b1100, 4'b1010, 3'b001, 1'b0, 4'b1110, 1'b0, 1'b1, 0};
        vecs[2]  = '{4'b1100, 4'b1010, 3'b010, 1'b0, 4'b0110, 1'b0, 1'b0, 0};
        vecs[3]  = '{4'b1100, 4'b1010, 3'b011, 1'b0, 4'b0011, 1'b0, 1'b0, 3};
        vecs[4]  = '{4'b0101, 4'b1010, 3'b110, 1'b0, 4'b0000, 1'b1, 1'b0, 0};
        vecs[5]  = '{4'b0001, 4'b0011, 3'b100, 1'b0, 4'b1110, 1'b0, 1'b1, 3};
        vecs[6]  = '{4'b0000, 4'b0110, 3'b111, 1'b0, 4'b0110, 1'b0, 1'b0, 2};
        vecs[7]  = '{4'b0000, 4'b0011, 3'b010, 1'b1, 4'b0101, 1'b0, 1'b0, 2};
        vecs[8]  = '{4'b0000, 4'b0000, 3'b011, 1'b1, 4'b1010, 1'b0, 1'b0, 3};
        vecs[9]  = '{4'b1111, 4'b0110, 3'b111, 1'b0, 4'b0110, 1'b0, 1'b0, 0};
        vecs[10] = '{4'b1111, 4'b0011, 3'b010, 1'b1, 4'b0101, 1'b0, 1'b0, 0};
        vecs[11] = '{4'b1111, 4'b0000, 3'b011, 1'b1, 4'b1010, 1'b0, 1'b0, 3};
        vecs[12] = '{4'b0000, 4'b0000, 3'b101, 1'b0, 4'b1111, 1'b0, 1'b0, 0};
        vecs[13] = '{4'b1001, 4'b1011, 3'b111, 1'b0, 4'b1011, 1'b0, 1'b1, 0};
        vecs[14] = '{4'b0110, 4'b0011, 3'b101, 1'b0, 4'b1000, 1'b0, 1'b1, 3};

        // Reset state.
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_parity", 32'(parity), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Directed table with out_ready held high.
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ua,
                 vecs[i].res, vecs[i].z, vecs[i].p, 1'b1);
            if (vecs[i].gap > 0) idle(vecs[i].gap);
        end
        drain();

        // Backpressure: first result frozen, in_ready low once S1 also holds a beat.
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        send(4'b1111, 4'b0101, 3'b000, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0);
        send(4'b0001, 4'b0010, 3'b001, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
        fork
            send(4'b1111, 4'b0001, 3'b010, 1'b0, 4'b1110, 1'b0, 1'b1, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    chk("bp_result", 32'(result), 32'b0101);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #2;
                out_ready = 1'b1;
            end
        join
        idle(1);
        drain();

        // Reset with both stages full discards them and clears acc.
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        send(4'b1111, 4'b1111, 3'b000, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        send(4'b0000, 4'b0001, 3'b001, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        chk("pre_reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_zero", 32'(zero), 32'd1);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        model_acc = '0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        out_ready = 1'b1;
        send(4'b0110, 4'b1001, 3'b010, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b1);
        idle(1);
        drain();

        // Random beats with random backpressure.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [W-1:0] ra, rb, er, opa;
                    logic [2:0]   ro;
                    logic         ru;
                    ra = W'($urandom);
                    rb = W'($urandom);
                    ro = 3'($urandom);
                    ru = 1'($urandom_range(0, 1));
                    opa = ru ? model_acc : ra;
                    er = ref_op(opa, rb, ro);
                    send(ra, rb, ro, ru, er, (er == '0), ^er, 1'b0);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                idle(1);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #2;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
